// File: rtl/systime_counter.sv
// 64-bit free-running system time base with absolute load, periodic drift trim
// (skip or double one tick per period) and a one-cycle low-word wrap pulse.
module systime_counter #(
    parameter int TRIM_PERIOD_BITS = 32
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [63:0]                 load_data,
    input  logic                        load_en,
    input  logic [TRIM_PERIOD_BITS-1:0] trim_period,
    input  logic                        trim_slow,
    input  logic                        trim_en,
    output logic [63:0]                 time_out,
    output logic [31:0]                 systime,
    output logic                        wrap,
    output logic                        trim_active
);

    localparam logic [TRIM_PERIOD_BITS-1:0] CNT_ONE = TRIM_PERIOD_BITS'(1);

    logic [TRIM_PERIOD_BITS-1:0] period_q;
    logic [TRIM_PERIOD_BITS-1:0] trim_cnt;
    logic                        slow_q;

    logic                        trim_on;
    logic                        adjust;
    logic [1:0]                  inc;
    logic [32:0]                 low_sum;
    logic [63:0]                 next_time;
    logic [TRIM_PERIOD_BITS-1:0] next_cnt;

    // A trim_en edge always advances by exactly 1; the new schedule starts on the next edge.
    always_comb begin
        trim_on = (period_q != '0);
        adjust  = trim_on && !trim_en && (trim_cnt == period_q - CNT_ONE);
        inc     = 2'd1;
        if (adjust)
            inc = slow_q ? 2'd0 : 2'd2;
        low_sum   = {1'b0, time_out[31:0]} + 33'(inc);
        next_time = time_out + 64'(inc);
    end

    always_comb begin
        next_cnt = trim_cnt + CNT_ONE;
        if (load_en || trim_en || !trim_on || adjust)
            next_cnt = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            time_out    <= 64'd0;
            wrap        <= 1'b0;
            trim_active <= 1'b0;
            period_q    <= '0;
            slow_q      <= 1'b0;
            trim_cnt    <= '0;
        end else begin
            // The one-cycle load latency is relied on by the system block's sync compensation.
            if (load_en) begin
                time_out <= load_data;
                wrap     <= 1'b0;
            end else begin
                time_out <= next_time;
                wrap     <= low_sum[32];
            end
            if (trim_en) begin
                period_q    <= trim_period;
                slow_q      <= trim_slow;
                trim_active <= (trim_period != '0);
            end
            trim_cnt <= next_cnt;
        end
    end

    assign systime = time_out[31:0];

endmodule

// File: tb/tb_systime_counter.sv
// Directed, table-driven check of systime_counter: each record holds the inputs
// for one clock edge and the outputs expected right after that edge.
module tb_systime_counter;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] load_data;
    logic        load_en;
    logic [31:0] trim_period;
    logic        trim_slow;
    logic        trim_en;
    logic [63:0] time_out;
    logic [31:0] systime;
    logic        wrap;
    logic        trim_active;

    int n_vec = 0;
    int n_bad = 0;

    typedef struct {
        logic        rst;
        logic        load_en;
        logic [63:0] load_data;
        logic        trim_en;
        logic [31:0] period;
        logic        slow;
        logic [63:0] exp_time;
        logic        exp_wrap;
        logic        exp_active;
    } vec_t;

    vec_t tbl[$];

    systime_counter #(.TRIM_PERIOD_BITS(32)) dut (
        .clk(clk), .rst(rst), .load_data(load_data), .load_en(load_en),
        .trim_period(trim_period), .trim_slow(trim_slow), .trim_en(trim_en),
        .time_out(time_out), .systime(systime), .wrap(wrap), .trim_active(trim_active)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(bit r, bit le, logic [63:0] ld, bit te, logic [31:0] tp,
                                bit ts, logic [63:0] et, bit ew, bit ea);
        vec_t v;
        v.rst = r; v.load_en = le; v.load_data = ld; v.trim_en = te;
        v.period = tp; v.slow = ts; v.exp_time = et; v.exp_wrap = ew; v.exp_active = ea;
        return v;
    endfunction

    function automatic vec_t idle(logic [63:0] et, bit ew, bit ea);
        return mk(0, 0, 64'd0, 0, 32'd0, 0, et, ew, ea);
    endfunction

    task automatic apply(input vec_t v, input string name);
        @(negedge clk);
        rst = v.rst; load_en = v.load_en; load_data = v.load_data;
        trim_en = v.trim_en; trim_period = v.period; trim_slow = v.slow;
        @(posedge clk);
        #1;
        n_vec++;
        if (time_out !== v.exp_time) begin
            n_bad++;
            $display("FAIL %s[%0d] time_out got %h want %h", name, n_vec, time_out, v.exp_time);
        end
        if (systime !== v.exp_time[31:0]) begin
            n_bad++;
            $display("FAIL %s[%0d] systime got %h want %h", name, n_vec, systime, v.exp_time[31:0]);
        end
        if (wrap !== v.exp_wrap) begin
            n_bad++;
            $display("FAIL %s[%0d] wrap got %b want %b", name, n_vec, wrap, v.exp_wrap);
        end
        if (trim_active !== v.exp_active) begin
            n_bad++;
            $display("FAIL %s[%0d] trim_active got %b want %b", name, n_vec, trim_active, v.exp_active);
        end
    endtask

    initial begin
        logic [63:0] t3 [12] = '{101, 102, 103, 103, 104, 105, 106, 106, 107, 108, 109, 109};
        logic [63:0] t4 [9]  = '{111, 112, 114, 115, 116, 118, 119, 120, 122};
        logic [63:0] t5 [4]  = '{1001, 1001, 1002, 1002};

        rst = 1'b0; load_en = 1'b0; load_data = '0;
        trim_en = 1'b0; trim_period = '0; trim_slow = 1'b0;

        // reset then free run
        tbl.push_back(mk(1, 0, 64'd0, 0, 32'd0, 0, 64'd0, 0, 0));
        for (int i = 1; i <= 10; i++) tbl.push_back(idle(64'(i), 0, 0));
        // load just below a low-word wrap
        tbl.push_back(mk(0, 1, 64'h1_FFFF_FFFE, 0, 32'd0, 0, 64'h1_FFFF_FFFE, 0, 0));
        tbl.push_back(idle(64'h1_FFFF_FFFF, 0, 0));
        tbl.push_back(idle(64'h2_0000_0000, 1, 0));
        tbl.push_back(idle(64'h2_0000_0001, 0, 0));
        // slow trim, period 4, from 100
        tbl.push_back(mk(0, 1, 64'd100, 1, 32'd4, 1, 64'd100, 0, 1));
        for (int i = 0; i < 12; i++) tbl.push_back(idle(t3[i], 0, 1));
        // fast trim, period 3, then disable
        tbl.push_back(mk(0, 0, 64'd0, 1, 32'd3, 0, 64'd110, 0, 1));
        for (int i = 0; i < 9; i++) tbl.push_back(idle(t4[i], 0, 1));
        tbl.push_back(mk(0, 0, 64'd0, 1, 32'd0, 0, 64'd123, 0, 0));
        tbl.push_back(idle(64'd124, 0, 0));
        // load and trim on the same edge
        tbl.push_back(mk(0, 1, 64'd1000, 1, 32'd2, 1, 64'd1000, 0, 1));
        for (int i = 0; i < 4; i++) tbl.push_back(idle(t5[i], 0, 1));
        // reset beats a simultaneous load
        tbl.push_back(mk(1, 1, 64'd5555, 1, 32'd7, 0, 64'd0, 0, 0));
        for (int i = 1; i <= 3; i++) tbl.push_back(idle(64'(i), 0, 0));

        foreach (tbl[i]) apply(tbl[i], "table");

        // double tick across the low-word boundary: exactly one wrap pulse
        apply(mk(0, 1, 64'hFFFF_FFFE, 1, 32'd1, 0, 64'hFFFF_FFFE, 0, 1), "inc2_wrap");
        apply(idle(64'h1_0000_0000, 1, 1), "inc2_wrap");
        apply(idle(64'h1_0000_0002, 0, 1), "inc2_wrap");
        apply(mk(0, 1, 64'hFFFF_FFFF, 0, 32'd0, 0, 64'hFFFF_FFFF, 0, 1), "inc2_wrap");
        apply(idle(64'h1_0000_0001, 1, 1), "inc2_wrap");
        // loading a lower value never raises wrap
        apply(mk(0, 1, 64'd3, 0, 32'd0, 0, 64'd3, 0, 1), "load_nowrap");
        // full 64-bit rollover
        apply(mk(0, 0, 64'd0, 1, 32'd0, 0, 64'd4, 0, 0), "rollover");
        apply(mk(0, 1, 64'hFFFF_FFFF_FFFF_FFFF, 0, 32'd0, 0, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0), "rollover");
        apply(idle(64'd0, 1, 0), "rollover");
        apply(idle(64'd1, 0, 0), "rollover");
        // period 1 slow: the capture edge still ticks, then time freezes
        apply(mk(0, 0, 64'd0, 1, 32'd1, 1, 64'd2, 0, 1), "freeze");
        apply(idle(64'd2, 0, 1), "freeze");
        apply(idle(64'd2, 0, 1), "freeze");
        apply(mk(0, 0, 64'd0, 1, 32'd0, 0, 64'd3, 0, 0), "freeze");
        apply(idle(64'd4, 0, 0), "freeze");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
